// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO / HEX / LED peripheral: register word offsets,
// reset constants and the seven-segment lookup.
package gpio_pkg;

   typedef logic [6:0] seg_t;

   // Word offsets (byte address [4:2])
   localparam logic [2:0] OFF_HEX_DATA  = 3'd0;  // 0x00
   localparam logic [2:0] OFF_HEX_BLANK = 3'd1;  // 0x04
   localparam logic [2:0] OFF_LEDG      = 3'd2;  // 0x08
   localparam logic [2:0] OFF_SW        = 3'd3;  // 0x0C
   localparam logic [2:0] OFF_BTN       = 3'd4;  // 0x10
   localparam logic [2:0] OFF_BTN_EDGE  = 3'd5;  // 0x14
   localparam logic [2:0] OFF_IRQ_EN    = 3'd6;  // 0x18

   localparam logic [3:0] HEX_BLANK_RST = 4'hF;
   localparam seg_t       SEG_OFF       = 7'h7F;

   // Segments {g,f,e,d,c,b,a}, active-low
   function automatic seg_t seg7_decode(input logic [3:0] nib);
      seg_t seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchroniser, optional debounce (GPIO_BTN_DEBOUNCE_EN),
// pressed level and a one-cycle pulse on each new press.
module btn_debounce
   import gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
)(
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pressed,
   output logic rise
);

   logic btn_meta;
   logic btn_sync;
   logic pressed_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta  <= 1'b1;
         btn_sync  <= 1'b1;
         pressed_q <= 1'b0;
      end else begin
         btn_meta  <= btn;
         btn_sync  <= btn_meta;
         pressed_q <= pressed;
      end
   end

`ifdef GPIO_BTN_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             level;

   // Down-counter reloads on any match; reaching zero on a mismatch accepts the new level
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= CNT_LOAD;
         level <= 1'b1;
      end else if (btn_sync == level) begin
         cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
         level <= btn_sync;
         cnt   <= CNT_LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign pressed = ~level;
`else
   assign pressed = ~btn_sync;
`endif

   assign rise = pressed & ~pressed_q;

endmodule

// File: rtl/gpio_hex_led.sv
// Memory-mapped GPIO: HEX3..0 and LEDG outputs, SW/BUTTON inputs, sticky press flags and irq.
// Button debounce is built only when GPIO_BTN_DEBOUNCE_EN is defined.
module gpio_hex_led
   import gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SW_W            = 10,
   parameter int unsigned BTN_W           = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             we,
   input  logic [2:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [SW_W-1:0]  sw,
   input  logic [BTN_W-1:0] btn,
   output logic [6:0]       hex3,
   output logic [6:0]       hex2,
   output logic [6:0]       hex1,
   output logic [6:0]       hex0,
   output logic [9:0]       ledg,
   output logic             irq
);

   logic [15:0]      hex_data;
   logic [3:0]       hex_blank;
   logic [9:0]       ledg_reg;
   logic [BTN_W-1:0] btn_edge;
   logic [BTN_W-1:0] irq_en;
   logic [SW_W-1:0]  sw_meta;
   logic [SW_W-1:0]  sw_sync;
   logic [BTN_W-1:0] btn_pressed;
   logic [BTN_W-1:0] btn_rise;
   logic [BTN_W-1:0] edge_clr;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             rd;
   logic             unused_wdata;

   assign wr           = cs & we;
   assign rd           = cs & ~we;
   assign unused_wdata = ^wdata[31:16];

   for (genvar i = 0; i < BTN_W; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
         .clk     (clk),
         .reset   (reset),
         .btn     (btn[i]),
         .pressed (btn_pressed[i]),
         .rise    (btn_rise[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

   assign edge_clr = (wr && addr == OFF_BTN_EDGE) ? wdata[BTN_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         hex_data  <= '0;
         hex_blank <= HEX_BLANK_RST;
         ledg_reg  <= '0;
         irq_en    <= '0;
         btn_edge  <= '0;
      end else begin
         if (wr) begin
            case (addr)
               OFF_HEX_DATA:  hex_data  <= wdata[15:0];
               OFF_HEX_BLANK: hex_blank <= wdata[3:0];
               OFF_LEDG:      ledg_reg  <= wdata[9:0];
               OFF_IRQ_EN:    irq_en    <= wdata[BTN_W-1:0];
               default: ;
            endcase
         end
         // A press landing with a W1C of the same bit keeps the flag set
         btn_edge <= (btn_edge & ~edge_clr) | btn_rise;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         OFF_HEX_DATA:  rd_mux[15:0]      = hex_data;
         OFF_HEX_BLANK: rd_mux[3:0]       = hex_blank;
         OFF_LEDG:      rd_mux[9:0]       = ledg_reg;
         OFF_SW:        rd_mux[SW_W-1:0]  = sw_sync;
         OFF_BTN:       rd_mux[BTN_W-1:0] = btn_pressed;
         OFF_BTN_EDGE:  rd_mux[BTN_W-1:0] = btn_edge;
         OFF_IRQ_EN:    rd_mux[BTN_W-1:0] = irq_en;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (rd) begin
         rdata <= rd_mux;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hex3 <= SEG_OFF;
         hex2 <= SEG_OFF;
         hex1 <= SEG_OFF;
         hex0 <= SEG_OFF;
         ledg <= '0;
      end else begin
         hex3 <= hex_blank[3] ? SEG_OFF : seg7_decode(hex_data[15:12]);
         hex2 <= hex_blank[2] ? SEG_OFF : seg7_decode(hex_data[11:8]);
         hex1 <= hex_blank[1] ? SEG_OFF : seg7_decode(hex_data[7:4]);
         hex0 <= hex_blank[0] ? SEG_OFF : seg7_decode(hex_data[3:0]);
         ledg <= ledg_reg;
      end
   end

   assign irq = |(btn_edge & irq_en);

endmodule

// File: tb/tb_gpio_hex_led.sv
// Bench for gpio_hex_led: register table, directed button sequences and random traffic
// checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_gpio_hex_led;

   localparam int DB = 4;
`ifdef GPIO_BTN_DEBOUNCE_EN
   localparam int DB_EFF = DB;
`else
   localparam int DB_EFF = 0;
`endif

   logic        clk = 1'b0;
   logic        reset, cs, we;
   logic [2:0]  addr;
   logic [31:0] wdata, rdata;
   logic [9:0]  sw;
   logic [2:0]  btn;
   logic [6:0]  hex3, hex2, hex1, hex0;
   logic [9:0]  ledg;
   logic        irq;

   always #5 clk = ~clk;

   gpio_hex_led #(.DEBOUNCE_CYCLES(DB), .SW_W(10), .BTN_W(3)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .sw(sw), .btn(btn), .hex3(hex3), .hex2(hex2), .hex1(hex1),
      .hex0(hex0), .ledg(ledg), .irq(irq)
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [15:0] m_hex_data;
   logic [3:0]  m_blank;
   logic [9:0]  m_ledg, m_ledg_out, m_sw1, m_sw2;
   logic [2:0]  m_edge, m_irq_en, m_b1, m_b2, m_acc, m_p, m_pq;
   logic [31:0] m_rdata;
   logic [6:0]  m_hex [4];
   logic [2:0]  m_hist [$];

   always @(posedge clk) begin
      logic [2:0]  ev, acc_n, p_n, clr;
      logic [31:0] rmux;
      bit          flip;
      if (reset) begin
         m_hex_data = '0; m_blank = 4'hF; m_ledg = '0; m_ledg_out = '0;
         m_sw1 = '0; m_sw2 = '0; m_edge = '0; m_irq_en = '0;
         m_b1 = 3'b111; m_b2 = 3'b111; m_acc = 3'b111; m_p = '0; m_pq = '0;
         m_rdata = '0; m_hist.delete();
         for (int n = 0; n < 4; n++) m_hex[n] = 7'h7F;
      end else begin
         ev = m_p & ~m_pq;
         // accepted level flips once the last DB synced samples all disagree with it
         m_hist.push_back(m_b2);
         if (m_hist.size() > DB) void'(m_hist.pop_front());
         acc_n = m_acc;
         for (int i = 0; i < 3; i++) begin
            flip = (m_hist.size() == DB);
            foreach (m_hist[k]) if (m_hist[k][i] == m_acc[i]) flip = 0;
            if (flip) acc_n[i] = ~m_acc[i];
         end
         p_n = (DB_EFF == 0) ? ~m_b1 : ~acc_n;

         case (addr)
            3'd0: rmux = 32'(m_hex_data);
            3'd1: rmux = 32'(m_blank);
            3'd2: rmux = 32'(m_ledg);
            3'd3: rmux = 32'(m_sw2);
            3'd4: rmux = 32'(m_p);
            3'd5: rmux = 32'(m_edge);
            3'd6: rmux = 32'(m_irq_en);
            default: rmux = '0;
         endcase
         if (cs && !we) m_rdata = rmux;
         clr = (cs && we && addr == 3'd5) ? wdata[2:0] : 3'b000;

         for (int n = 0; n < 4; n++)
            m_hex[n] = m_blank[n] ? 7'h7F : seg_tab[m_hex_data[4*n +: 4]];
         m_ledg_out = m_ledg;

         if (cs && we) begin
            case (addr)
               3'd0: m_hex_data = wdata[15:0];
               3'd1: m_blank    = wdata[3:0];
               3'd2: m_ledg     = wdata[9:0];
               3'd6: m_irq_en   = wdata[2:0];
               default: ;
            endcase
         end
         m_edge = (m_edge & ~clr) | ev;
         m_sw2 = m_sw1; m_sw1 = sw;
         m_b2 = m_b1;   m_b1 = btn;
         m_acc = acc_n; m_pq = m_p; m_p = p_n;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("hex3",  32'(hex3),  32'(m_hex[3]));
         check("hex2",  32'(hex2),  32'(m_hex[2]));
         check("hex1",  32'(hex1),  32'(m_hex[1]));
         check("hex0",  32'(hex0),  32'(m_hex[0]));
         check("ledg",  32'(ledg),  32'(m_ledg_out));
         check("irq",   32'(irq),   32'(|(m_edge & m_irq_en)));
         check("rdata", rdata,      m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d);
      cs = 1'b1; we = w; addr = a; wdata = d;
      tick();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      bus(1'b0, a, 32'h0);
      check(name, rdata, exp);
   endtask

   typedef struct {
      logic        w;
      logic [2:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [18];

   initial begin
      vecs = '{
         '{1'b1, 3'd0, 32'h0000_12AF, 32'h0},
         '{1'b1, 3'd1, 32'h0000_0000, 32'h0},
         '{1'b0, 3'd0, 32'h0,         32'h0000_12AF},
         '{1'b0, 3'd1, 32'h0,         32'h0},
         '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0},
         '{1'b0, 3'd2, 32'h0,         32'h0000_03FF},
         '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0},
         '{1'b0, 3'd3, 32'h0,         32'h0},
         '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0},
         '{1'b0, 3'd7, 32'h0,         32'h0},
         '{1'b1, 3'd6, 32'hFFFF_FFFD, 32'h0},
         '{1'b0, 3'd6, 32'h0,         32'h5},
         '{1'b1, 3'd6, 32'h0,         32'h0},
         '{1'b1, 3'd1, 32'hFFFF_FFF5, 32'h0},
         '{1'b0, 3'd1, 32'h0,         32'h5},
         '{1'b1, 3'd1, 32'h0,         32'h0},
         '{1'b1, 3'd0, 32'hABCD_12AF, 32'h0},
         '{1'b0, 3'd0, 32'h0,         32'h0000_12AF}
      };

      reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      sw = '0; btn = 3'b111;
      @(posedge clk);
      #1 chk_on = 1;
      tick(); tick();
      reset = 1'b0;

      // 1. reset / idle
      repeat (3) tick();
      check("rst_hex3", 32'(hex3), 32'h7F);
      check("rst_hex0", 32'(hex0), 32'h7F);
      check("rst_ledg", 32'(ledg), 32'h0);
      check("rst_irq",  32'(irq),  32'h0);
      rd_chk("rst_btn", 3'd4, 32'h0);

      // 2/3. register table
      for (int i = 0; i < 18; i++) begin
         bus(vecs[i].w, vecs[i].a, vecs[i].d);
         if (!vecs[i].w) check($sformatf("vec%0d_rd", i), rdata, vecs[i].exp);
      end
      tick();
      check("hex3_1", 32'(hex3), 32'h79);
      check("hex2_2", 32'(hex2), 32'h24);
      check("hex1_A", 32'(hex1), 32'h08);
      check("hex0_F", 32'(hex0), 32'h0E);
      check("ledg_all", 32'(ledg), 32'h3FF);

      sw = 10'h2A5;
      tick(); tick();
      rd_chk("sw_sync", 3'd3, 32'h2A5);

      // 4. glitch shorter than the debounce window, then a real press
      btn = 3'b101;
      repeat (3) tick();
      btn = 3'b111;
      repeat (10) tick();
      rd_chk("glitch_btn", 3'd4, 32'h0);
      rd_chk("glitch_edge", 3'd5, (DB_EFF == 0) ? 32'h2 : 32'h0);
      bus(1'b1, 3'd5, 32'h7);
      btn = 3'b101;
      repeat (10) tick();
      rd_chk("press_btn", 3'd4, 32'h2);
      rd_chk("press_edge", 3'd5, 32'h2);

      // 5. irq and W1C, including W1C colliding with a new press
      bus(1'b1, 3'd6, 32'h2);
      check("irq_set", 32'(irq), 32'h1);
      bus(1'b1, 3'd5, 32'h2);
      check("irq_clr", 32'(irq), 32'h0);
      btn = 3'b111;
      repeat (12) tick();
      rd_chk("release_edge", 3'd5, 32'h0);
      btn = 3'b101;
      repeat (2 + DB_EFF) tick();
      bus(1'b1, 3'd5, 32'h2);
      rd_chk("w1c_race_edge", 3'd5, 32'h2);
      check("w1c_race_irq", 32'(irq), 32'h1);
      bus(1'b1, 3'd5, 32'h2);
      btn = 3'b111;
      repeat (12) tick();

      // 6. reset in the middle of a debounce
      btn = 3'b110;
      repeat (4) tick();
      reset = 1'b1;
      btn = 3'b111;
      tick(); tick();
      reset = 1'b0;
      repeat (12) tick();
      rd_chk("mid_rst_btn", 3'd4, 32'h0);
      rd_chk("mid_rst_edge", 3'd5, 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_hex0", 32'(hex0), 32'h7F);
      rd_chk("off_1c", 3'd7, 32'h0);

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
         if ($urandom_range(0, 7) == 0) sw = 10'($urandom());
         reset = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 2) == 0) begin
            bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom());
         end else begin
            tick();
         end
      end
      reset = 1'b0;
      tick();
      chk_on = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
